// File: rtl/denorm_shift_pkg.sv
// Shared constants and types for the denormalizing shifter and its companion normalizer.
package denorm_shift_pkg;

    localparam int MANTISSA_DEF = 11;
    localparam int EXPONENT_DEF = 5;
    localparam int MAX_SHIFT    = MANTISSA_DEF - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        state_e state;
        logic   rb;
    } dbg_t;

endpackage

// File: rtl/denorm_shift_if.sv
// Operand/result handshake bundle for denorm_shift.
interface denorm_shift_if #(
    parameter int MANTISSA = 11,
    parameter int EXPONENT = 5
);
    // Both sides transfer on a rising edge where valid and ready are high together;
    // a producer holds its payload stable while valid is high and ready is low.
    logic [MANTISSA-1:0] in_mantissa;
    logic [EXPONENT-1:0] en_in;
    logic                in_valid;
    logic                in_ready;
    logic [MANTISSA-1:0] out_mantissa;
    logic                out_sat;
    logic                out_valid;
    logic                out_ready;

    modport slave (
        input  in_mantissa, en_in, in_valid, out_ready,
        output in_ready, out_mantissa, out_sat, out_valid
    );

    modport master (
        output in_mantissa, en_in, in_valid, out_ready,
        input  in_ready, out_mantissa, out_sat, out_valid
    );
endinterface

// File: rtl/denorm_shift.sv
// Serial denormalizer: arithmetic right shift by a clamped count, one bit per cycle,
// then round-half-up by adding the last bit shifted out.
module denorm_shift
    import denorm_shift_pkg::*;
#(
    parameter int MANTISSA = MANTISSA_DEF,
    parameter int EXPONENT = EXPONENT_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    denorm_shift_if.slave bus,
    output dbg_t          dbg
);

    localparam logic [EXPONENT-1:0] KMAX = EXPONENT'(MANTISSA - 1);

    state_e              state_q, state_d;
    logic [MANTISSA-1:0] mant_q, mant_d;
    logic [EXPONENT-1:0] cnt_q, cnt_d;
    logic                rb_q, rb_d;
    logic                sat_q, sat_d;

    logic                in_ready_c;
    logic                sat_in;
    logic [EXPONENT-1:0] k_in;
    logic [MANTISSA-1:0] shifted;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            mant_q  <= '0;
            cnt_q   <= '0;
            rb_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            cnt_q   <= cnt_d;
            rb_q    <= rb_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mant_d     = mant_q;
        cnt_d      = cnt_q;
        rb_d       = rb_q;
        sat_d      = sat_q;
        in_ready_c = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
        sat_in     = bus.en_in > KMAX;
        k_in       = sat_in ? KMAX : bus.en_in;
        shifted    = {mant_q[MANTISSA-1], mant_q[MANTISSA-1:1]};

        if (bus.in_valid && in_ready_c) begin
            // Capture also covers the HOLD drain cycle, giving back-to-back throughput.
            mant_d  = bus.in_mantissa;
            cnt_d   = k_in;
            sat_d   = sat_in;
            rb_d    = 1'b0;
            state_d = (k_in == '0) ? HOLD : SHIFT;
        end else begin
            case (state_q)
                SHIFT: begin
                    rb_d  = mant_q[0];
                    cnt_d = cnt_q - EXPONENT'(1);
                    if (cnt_q == EXPONENT'(1)) begin
                        // At least one shift has happened, so the increment cannot overflow.
                        mant_d  = shifted + {{(MANTISSA-1){1'b0}}, mant_q[0]};
                        state_d = HOLD;
                    end else begin
                        mant_d = shifted;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready     = rstn & in_ready_c;
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.out_mantissa = mant_q;
    assign bus.out_sat      = sat_q;
    assign dbg              = '{state: state_q, rb: rb_q};

endmodule

// File: tb/tb_denorm_shift.sv
// Bench for denorm_shift: directed corner cases plus random traffic checked by a scoreboard.
module tb_denorm_shift;
    import denorm_shift_pkg::*;

    localparam int M = 11;
    localparam int E = 5;

    logic clk;
    logic rstn;
    dbg_t dbg;

    denorm_shift_if #(.MANTISSA(M), .EXPONENT(E)) bus ();

    denorm_shift #(.MANTISSA(M), .EXPONENT(E)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .dbg  (dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    logic [M:0] exp_q[$];
    int         acc_q[$];
    int         k_q[$];
    int         total = 0;
    int         bad   = 0;
    bit         got_first = 0;
    bit         prev_hold = 0;
    logic [M:0] prev_data;
    bit         rand_rdy = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: round-half-up of x / 2^k with k clamped to M-1.
    function automatic logic [M:0] model(input logic [M-1:0] m, input int e);
        int   x, k, r;
        logic sat;
        sat = (e > M - 1);
        k   = sat ? M - 1 : e;
        x   = int'(m);
        if (m[M-1]) x = x - (1 << M);
        if (k == 0) r = x;
        else        r = (x + (1 << (k - 1))) >>> k;
        return {sat, M'(r)};
    endfunction

    function automatic int clamp_k(input int e);
        return (e > M - 1) ? M - 1 : e;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [M-1:0] m, input int e);
        bit done;
        done            = 0;
        bus.in_valid    = 1'b1;
        bus.in_mantissa = m;
        bus.en_in       = E'(e);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(m, e));
                acc_q.push_back(cyc + 1);
                k_q.push_back(clamp_k(e));
                done = 1;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rstn) begin
            got_first = 0;
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_data", int'({bus.out_sat, bus.out_mantissa}), int'(prev_data));
            end
            if (bus.out_valid && !got_first) begin
                got_first = 1;
                if (acc_q.size() == 0) chk("spurious_valid", 1, 0);
                else chk("latency", cyc - acc_q[0] + 1, k_q[0] + 1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("result", int'({bus.out_sat, bus.out_mantissa}), int'(exp_q.pop_front()));
                    void'(acc_q.pop_front());
                    void'(k_q.pop_front());
                end
                got_first = 0;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = {bus.out_sat, bus.out_mantissa};
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rstn            = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_mantissa = '0;
        bus.en_in       = '0;
        bus.out_ready   = 1'b1;

        #3;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_mant", int'(bus.out_mantissa), 0);
        chk("rst_out_sat", int'(bus.out_sat), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(bus.in_ready), 1);
        chk("post_rst_state", int'(dbg.state), int'(IDLE));
        @(posedge clk);
        #1;

        // directed corner cases
        send(11'h200, 3);
        send(11'h005, 1);
        send(11'h7F6, 2);
        send(11'h3FF, 20);
        send(11'h155, 0);
        send(11'h400, 10);
        send(11'h3FF, 10);
        drain();

        // stalled HOLD, then drain and accept in the same cycle
        bus.out_ready = 1'b0;
        send(11'h123, 2);
        begin
            bit seen;
            seen = 0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1;
            end
            chk("stall_valid_seen", int'(seen), 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", int'(bus.in_ready), 0);
            chk("stall_out_valid", int'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(11'h0F0, 1);
        @(negedge clk);
        chk("b2b_state", int'(dbg.state), int'(SHIFT));
        chk("b2b_out_valid", int'(bus.out_valid), 0);
        drain();

        // asynchronous reset in the middle of a shift
        send(11'h7A5, 8);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_out_mant", int'(bus.out_mantissa), 0);
        chk("midrst_out_sat", int'(bus.out_sat), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        chk("midrst_state", int'(dbg.state), int'(IDLE));
        exp_q.delete();
        acc_q.delete();
        k_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("relrst_in_ready", int'(bus.in_ready), 1);
        chk("relrst_out_valid", int'(bus.out_valid), 0);
        repeat (10) @(negedge clk);
        chk("relrst_no_stale", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;

        // random traffic with random backpressure
        rand_rdy = 1;
        for (int n = 0; n < 60; n++) begin
            int e;
            if ($urandom_range(0, 3) == 0) e = $urandom_range(M, (1 << E) - 1);
            else                           e = $urandom_range(0, M - 1);
            send(M'($urandom), e);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        drain();
        rand_rdy = 0;
        #2;
        bus.out_ready = 1'b1;
        drain();
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/denorm_shift.md
DENORM_SHIFT -- requirements
Module: denorm_shift

Interface
REQ-001 Parameter MANTISSA, default 11: two's-complement mantissa width.
REQ-002 Parameter EXPONENT, default 5: shift-count width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 in_mantissa  input  MANTISSA  normalized two's-complement mantissa.
REQ-006 en_in  input  EXPONENT  unsigned right-shift count, i.e. the normalizer's shift amount.
REQ-007 in_valid  input  1  in_mantissa/en_in valid.
REQ-008 in_ready  output  1  block can accept an operand this cycle.
REQ-009 out_mantissa  output  MANTISSA  denormalized, rounded result.
REQ-010 out_sat  output  1  en_in exceeded MANTISSA-1 and was clamped.
REQ-011 out_valid  output  1  out_mantissa/out_sat valid.
REQ-012 out_ready  input  1  consumer accepts result.

Function
REQ-013 Transfer on the input side SHALL occur when in_valid and in_ready are both high at a rising edge; on the output side, when out_valid and out_ready are both high.
REQ-014 FSM states SHALL be IDLE, SHIFT and HOLD.
REQ-015 IDLE: in_ready=1 and out_valid=0; on an input transfer, capture the mantissa and k=min(en_in, MANTISSA-1), and set the sat flag to (en_in > MANTISSA-1).
REQ-016 From IDLE, k=0 SHALL go to HOLD with the mantissa unchanged; k>0 SHALL go to SHIFT.
REQ-017 SHIFT: each cycle, arithmetic shift right by 1 (sign-replicating), record the shifted-out bit as the round bit, and decrement the count.
REQ-018 On the SHIFT cycle where the count reaches 0, the next state SHALL be HOLD, with result = shifted value + round bit.
REQ-019 Rounding SHALL be round-half-up, i.e. add the last shifted-out bit. This rounding never overflows because k>=1 guarantees headroom, so no saturation logic is required.
REQ-020 Latency from the input transfer to out_valid SHALL be exactly 1+k cycles.
REQ-021 HOLD: out_valid=1; out_mantissa and out_sat SHALL be held stable while out_ready=0.
REQ-022 HOLD with out_ready=1 SHALL assert in_ready=1 combinationally, so a new operand is accepted in the same cycle.
REQ-023 HOLD with out_ready=1 and in_valid=1 SHALL behave as the IDLE capture, giving back-to-back throughput.
REQ-024 HOLD with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-025 in_ready SHALL be 0 in SHIFT, and in HOLD while out_ready=0.
REQ-026 Input signal changes while in_ready=0 SHALL be ignored.

Reset
REQ-027 rstn=0 SHALL immediately force the following, regardless of clk or state: state=IDLE, out_mantissa=0, out_sat=0, out_valid=0, internal count and round bit=0.
REQ-028 in_ready SHALL be 0 while rstn=0 and SHALL be 1 in the first cycle after deassertion.
REQ-029 Reset asserted during SHIFT or HOLD SHALL discard the in-flight operand, with no output transfer.

Structure
REQ-030 A shared package SHALL hold the MANTISSA/EXPONENT defaults, the state enumeration, and the MAX_SHIFT = MANTISSA-1 constant, shared with the normalizer.
REQ-031 The block SHALL be a single module with no sub-module; the shift/round datapath is inline.

Verification
REQ-032 in_mantissa=0x200, en_in=3 -> out_mantissa=0x040, out_sat=0, out_valid 4 cycles after accept.
REQ-033 in_mantissa=0x005, en_in=1 -> out_mantissa=0x003 (2.5 rounds up); in_mantissa=0x7F6 (-10), en_in=2 -> out_mantissa=0x7FE (-2).
REQ-034 in_mantissa=0x3FF, en_in=20 -> out_sat=1, out_mantissa=0x001, latency 11 cycles; en_in=0 with 0x155 -> 0x155 after 1 cycle.
REQ-035 out_ready held low 5 cycles in HOLD -> out_mantissa and out_valid stable and in_ready=0; then out_ready=1 with in_valid=1 -> output transfer and new accept in the same cycle.
REQ-036 rstn pulsed low mid-SHIFT (en_in=8, cycle 3) -> outputs 0 without a clock edge; after release in_ready=1 and no stale out_valid.
